// File: rtl/ctr_drbg_pkg.sv
// Shared types and helpers for the CTR_DRBG update datapath.
// Used by the update engine and its block-cipher interface.
package ctr_drbg_pkg;

  localparam int BLK_LEN     = 128;
  localparam int KEY_LEN_128 = 128;
  localparam int KEY_LEN_192 = 192;
  localparam int KEY_LEN_256 = 256;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INC  = 3'd1,
    REQ  = 3'd2,
    WAIT = 3'd3,
    FIN  = 3'd4
  } upd_state_t;

  function automatic int nblocks(input int key_len);
    return (key_len + BLK_LEN + BLK_LEN - 1) / BLK_LEN;
  endfunction

  function automatic bit key_len_legal(input int key_len);
    return (key_len == KEY_LEN_128) || (key_len == KEY_LEN_192) || (key_len == KEY_LEN_256);
  endfunction

endpackage

// File: rtl/ctr_drbg_update_param_if.sv
// Request/response link between the update engine and the shared AES core.
interface ctr_drbg_update_param_if #(
  parameter int KEY_LEN = 256
);

  logic               aes_req;
  logic               aes_ack;
  logic [KEY_LEN-1:0] aes_key;
  logic [127:0]       aes_pt;
  logic               aes_vld;
  logic [127:0]       aes_ct;

  modport master (output aes_req, aes_key, aes_pt, input aes_ack, aes_vld, aes_ct);
  modport slave  (input aes_req, aes_key, aes_pt, output aes_ack, aes_vld, aes_ct);

endinterface

// File: rtl/ctr_drbg_ctr_inc.sv
// Increment of the low CTR_LEN bits of V; the upper bits pass through untouched.
module ctr_drbg_ctr_inc #(
  parameter int CTR_LEN = 128
) (
  input  logic [127:0] v_in,
  output logic [127:0] v_out
);

  if (CTR_LEN >= 128) begin : g_full
    assign v_out = v_in + 128'd1;
  end else begin : g_masked
    logic [CTR_LEN-1:0] ctr_s;
    assign ctr_s = v_in[CTR_LEN-1:0] + CTR_LEN'(1);
    assign v_out = {v_in[127:CTR_LEN], ctr_s};
  end

endmodule

// File: rtl/ctr_drbg_update_param_chk.sv
// Protocol monitor for the AES link of the update engine.
module ctr_drbg_update_param_chk (
  input logic clk,
  input logic rst,
  input logic in_req,
  input logic aes_ack,
  input logic aes_vld
);

  // a result may only arrive once the request has been accepted
  a_vld_after_ack: assert property (@(posedge clk) disable iff (!rst) !(in_req && aes_vld && !aes_ack))
    else $error("ctr_drbg_update_param: aes_vld while requesting without aes_ack");

endmodule

// File: rtl/ctr_drbg_update_param.sv
// CTR_DRBG Update (no derivation function): N AES calls on incremented V,
// keystream XOR provided_data, then Key/V committed together with done.
module ctr_drbg_update_param
  import ctr_drbg_pkg::*;
#(
  parameter int  KEY_LEN = 256,
  parameter int  CTR_LEN = 128,
  localparam int SEEDLEN = KEY_LEN + 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   clear,
  input  logic [SEEDLEN-1:0]     provided_data,
  ctr_drbg_update_param_if.master aes,
  output logic [KEY_LEN-1:0]     key,
  output logic [127:0]           v,
  output logic                   busy,
  output logic                   done
);

  localparam int         NBLK     = nblocks(KEY_LEN);
  localparam int         TEMP_LEN = NBLK * BLK_LEN;
  localparam logic [1:0] LAST_BLK = 2'(NBLK - 1);

  if (!key_len_legal(KEY_LEN)) begin : g_bad_key_len
    $error("ctr_drbg_update_param: KEY_LEN %0d must be 128, 192 or 256", KEY_LEN);
  end
  if (CTR_LEN < 32 || CTR_LEN > 128) begin : g_bad_ctr_len
    $error("ctr_drbg_update_param: CTR_LEN %0d must be within 32..128", CTR_LEN);
  end

  upd_state_t          state_r, state_s;
  logic [KEY_LEN-1:0]  key_r;
  logic [127:0]        v_r, v_inc_s;
  logic [SEEDLEN-1:0]  pd_r, t_s;
  logic [TEMP_LEN-1:0] temp_r;
  logic [1:0]          blk_r;
  logic                busy_r, done_r, aes_req_r;
  logic                last_s, take_s;

  ctr_drbg_ctr_inc #(.CTR_LEN(CTR_LEN)) u_inc (.v_in(v_r), .v_out(v_inc_s));

  ctr_drbg_update_param_chk u_chk (
    .clk     (clk),
    .rst     (rst),
    .in_req  (state_r == REQ),
    .aes_ack (aes.aes_ack),
    .aes_vld (aes.aes_vld)
  );

  assign last_s = (blk_r == LAST_BLK);
  // for KEY_LEN=192 the low 64 keystream bits are dropped
  assign t_s    = temp_r[TEMP_LEN-1 -: SEEDLEN] ^ pd_r;

  // next state; a result arriving in the ack cycle completes the block at once
  always_comb begin
    state_s = state_r;
    take_s  = 1'b0;
    case (state_r)
      IDLE: if (start) state_s = INC; else state_s = IDLE;
      INC:  state_s = REQ;
      REQ: begin
        if (aes.aes_ack) begin
          take_s = aes.aes_vld;
          if (aes.aes_vld) state_s = last_s ? FIN : INC;
          else             state_s = WAIT;
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        if (aes.aes_vld) begin
          take_s  = 1'b1;
          state_s = last_s ? FIN : INC;
        end else begin
          state_s = WAIT;
        end
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // state, working registers and committed Key/V
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= IDLE;
      key_r     <= '0;
      v_r       <= '0;
      pd_r      <= '0;
      temp_r    <= '0;
      blk_r     <= 2'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      aes_req_r <= 1'b0;
    end else begin
      state_r <= state_s;
      done_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            pd_r   <= provided_data;
            blk_r  <= 2'd0;
            busy_r <= 1'b1;
            if (clear) begin
              key_r <= '0;
              v_r   <= '0;
            end
          end
        end
        INC: begin
          v_r       <= v_inc_s;
          aes_req_r <= 1'b1;
        end
        REQ: if (aes.aes_ack) aes_req_r <= 1'b0;
        FIN: begin
          key_r  <= t_s[SEEDLEN-1:BLK_LEN];
          v_r    <= t_s[BLK_LEN-1:0];
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end
        default: ;
      endcase
      if (take_s) begin
        for (int i = 0; i < NBLK; i++) begin
          if (blk_r == 2'(i)) temp_r[TEMP_LEN-1-i*BLK_LEN -: BLK_LEN] <= aes.aes_ct;
        end
        if (!last_s) blk_r <= blk_r + 2'd1;
      end
    end
  end

  assign key         = key_r;
  assign v           = v_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign aes.aes_req = aes_req_r;
  assign aes.aes_key = key_r;
  assign aes.aes_pt  = v_r;

endmodule

// File: tb/tb_ctr_drbg_update_param.sv
// Self-checking bench: three DUT lanes (256/ctr128, 128/ctr32, 192/ctr128), a stand-in
// block cipher with programmable ack/vld delay, and a scoreboard fed by a reference update model.
module tb_ctr_drbg_update_param;

  typedef struct packed { int lane; logic [255:0] key; logic [127:0] pt; } hs_t;
  typedef struct packed { int lane; logic [255:0] key; logic [127:0] v;  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start_r [3];
  logic         clear_r [3];
  logic [383:0] pd_r    [3];
  logic [255:0] key0;
  logic [127:0] key1;
  logic [191:0] key2;
  logic [255:0] key_w  [3];
  logic [127:0] v_w    [3];
  logic         busy_w [3];
  logic         done_w [3];
  logic         req_w  [3];
  logic         ack_w  [3];
  logic         vld_w  [3];
  logic [127:0] ct_w   [3];
  logic [255:0] akey_w [3];
  logic [127:0] apt_w  [3];
  logic [3:0]   ack_dly, vld_dly;
  logic [3:0]   rcnt [3];
  logic [3:0]   wcnt [3];
  logic [255:0] lkey [3];
  logic [127:0] lpt  [3];
  logic [255:0] mkey [3];
  logic [127:0] mv   [3];
  hs_t          hs_q [$];
  res_t         res_q [$];
  int           checks = 0;
  int           errors = 0;
  int           hs_cnt = 0;
  logic [127:0] first_pt;
  bit           mon_ok;

  ctr_drbg_update_param_if #(.KEY_LEN(256)) if0 ();
  ctr_drbg_update_param_if #(.KEY_LEN(128)) if1 ();
  ctr_drbg_update_param_if #(.KEY_LEN(192)) if2 ();

  ctr_drbg_update_param #(.KEY_LEN(256), .CTR_LEN(128)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_r[0]), .clear(clear_r[0]), .provided_data(pd_r[0]),
    .aes(if0), .key(key0), .v(v_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  ctr_drbg_update_param #(.KEY_LEN(128), .CTR_LEN(32)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_r[1]), .clear(clear_r[1]), .provided_data(pd_r[1][255:0]),
    .aes(if1), .key(key1), .v(v_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  ctr_drbg_update_param #(.KEY_LEN(192), .CTR_LEN(128)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_r[2]), .clear(clear_r[2]), .provided_data(pd_r[2][319:0]),
    .aes(if2), .key(key2), .v(v_w[2]), .busy(busy_w[2]), .done(done_w[2]));

  assign key_w[0]   = key0;
  assign key_w[1]   = {128'd0, key1};
  assign key_w[2]   = {64'd0, key2};
  assign req_w[0]   = if0.aes_req;
  assign req_w[1]   = if1.aes_req;
  assign req_w[2]   = if2.aes_req;
  assign akey_w[0]  = if0.aes_key;
  assign akey_w[1]  = {128'd0, if1.aes_key};
  assign akey_w[2]  = {64'd0, if2.aes_key};
  assign apt_w[0]   = if0.aes_pt;
  assign apt_w[1]   = if1.aes_pt;
  assign apt_w[2]   = if2.aes_pt;
  assign if0.aes_ack = ack_w[0];
  assign if1.aes_ack = ack_w[1];
  assign if2.aes_ack = ack_w[2];
  assign if0.aes_vld = vld_w[0];
  assign if1.aes_vld = vld_w[1];
  assign if2.aes_vld = vld_w[2];
  assign if0.aes_ct  = ct_w[0];
  assign if1.aes_ct  = ct_w[1];
  assign if2.aes_ct  = ct_w[2];

  function automatic logic [127:0] cipher(input logic [255:0] k, input logic [127:0] p);
    logic [127:0] r;
    r = {p[114:0], p[127:115]} ^ (p * 128'd3);
    return r ^ k[127:0] ^ {k[191:128], k[255:192]} ^ 128'hC3A5_5A3C_0F1E_2D4B_8796_A5B4_C3D2_E1F0;
  endfunction

  function automatic int lane_klen(input int l);
    return (l == 0) ? 256 : ((l == 1) ? 128 : 192);
  endfunction

  function automatic int lane_ctr(input int l);
    return (l == 1) ? 32 : 128;
  endfunction

  function automatic int lane_n(input int l);
    return (lane_klen(l) == 128) ? 2 : 3;
  endfunction

  function automatic logic [127:0] inc_v(input logic [127:0] vin, input int cl);
    logic [127:0] m;
    m = (cl == 128) ? ~128'd0 : ((128'd1 << cl) - 128'd1);
    return (vin & ~m) | ((vin + 128'd1) & m);
  endfunction

  function automatic logic [383:0] rnd384();
    logic [383:0] r;
    for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // behavioural AES stand-in: ack after ack_dly request cycles, result vld_dly cycles after ack
  always_comb begin
    for (int l = 0; l < 3; l++) begin
      ack_w[l] = req_w[l] && (rcnt[l] == ack_dly);
      vld_w[l] = (vld_dly == 4'd0) ? ack_w[l] : (wcnt[l] == 4'd1);
      ct_w[l]  = (vld_dly == 4'd0) ? cipher(akey_w[l], apt_w[l]) : cipher(lkey[l], lpt[l]);
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < 3; l++) begin
      if (!rst) begin
        rcnt[l] <= 4'd0;
        wcnt[l] <= 4'd0;
      end else begin
        if (req_w[l] && !ack_w[l]) rcnt[l] <= rcnt[l] + 4'd1;
        else                       rcnt[l] <= 4'd0;
        if (ack_w[l] && vld_dly != 4'd0) begin
          wcnt[l] <= vld_dly;
          lkey[l] <= akey_w[l];
          lpt[l]  <= apt_w[l];
        end else if (wcnt[l] != 4'd0) begin
          wcnt[l] <= wcnt[l] - 4'd1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic keystream(input int l, input logic [255:0] k, input logic [127:0] v0,
                           input bit push, output logic [383:0] ks);
    logic [127:0] vv;
    logic [383:0] tmp;
    vv  = v0;
    tmp = '0;
    for (int i = 0; i < lane_n(l); i++) begin
      vv = inc_v(vv, lane_ctr(l));
      if (push) hs_q.push_back('{lane: l, key: k, pt: vv});
      tmp[383-128*i -: 128] = cipher(k, vv);
    end
    ks = tmp >> (384 - lane_klen(l) - 128);
  endtask

  task automatic expect_update(input int l, input bit clr, input logic [383:0] pdv);
    logic [255:0] k;
    logic [127:0] vv;
    logic [383:0] ks, t;
    k  = clr ? 256'd0 : mkey[l];
    vv = clr ? 128'd0 : mv[l];
    keystream(l, k, vv, 1'b1, ks);
    t = ks ^ (pdv & (~384'd0 >> (384 - lane_klen(l) - 128)));
    mkey[l] = t[383:128];
    mv[l]   = t[127:0];
    res_q.push_back('{lane: l, key: t[383:128], v: t[127:0]});
  endtask

  // scoreboard: AES requests and completed updates against the queued expectations
  always @(negedge clk) begin
    if (rst) begin
      for (int l = 0; l < 3; l++) begin
        if (req_w[l]) begin
          mon_ok = (hs_q.size() != 0) && (hs_q[0].lane == l);
          chk("req_expected", mon_ok, 1);
          if (mon_ok) begin
            chk("aes_key", akey_w[l], hs_q[0].key);
            chk("aes_pt", apt_w[l], hs_q[0].pt);
            if (ack_w[l]) begin
              if (hs_cnt == 0) first_pt = apt_w[l];
              hs_cnt++;
              void'(hs_q.pop_front());
            end
          end
        end
        if (done_w[l]) begin
          mon_ok = (res_q.size() != 0) && (res_q[0].lane == l);
          chk("done_expected", mon_ok, 1);
          chk("busy_at_done", busy_w[l], 0);
          if (mon_ok) begin
            chk("key", key_w[l], res_q[0].key);
            chk("v", v_w[l], res_q[0].v);
            void'(res_q.pop_front());
          end
        end
      end
    end
  end

  task automatic run(input int l, input bit clr, input logic [383:0] pdv,
                     input int hold, input int pulse_at, input int exp_cyc);
    int e;
    bit seen;
    expect_update(l, clr, pdv);
    hs_cnt = 0;
    @(posedge clk); #1;
    start_r[l] = 1'b1;
    clear_r[l] = clr;
    pd_r[l]    = pdv;
    @(posedge clk); #1;
    e    = 0;
    seen = 1'b0;
    clear_r[l] = 1'b0;
    start_r[l] = (1 < hold) || (1 == pulse_at);
    while (!seen && e < 200) begin
      if (done_w[l]) begin
        seen = 1'b1;
      end else begin
        @(posedge clk); #1;
        e++;
        start_r[l] = (e + 1 < hold) || (e + 1 == pulse_at);
      end
    end
    start_r[l] = 1'b0;
    chk("done_seen", seen, 1);
    chk("latency", e + 1, exp_cyc);
    chk("handshakes", hs_cnt, lane_n(l));
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_done", busy_w[l], 0);
    chk("hs_drained", hs_q.size(), 0);
    chk("res_drained", res_q.size(), 0);
  endtask

  initial begin
    logic [383:0] ks, pdv;
    rst     = 1'b0;
    ack_dly = 4'd0;
    vld_dly = 4'd0;
    for (int l = 0; l < 3; l++) begin
      start_r[l] = 1'b0;
      clear_r[l] = 1'b0;
      pd_r[l]    = '0;
      mkey[l]    = '0;
      mv[l]      = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int l = 0; l < 3; l++) begin
      chk("rst_key", key_w[l], 0);
      chk("rst_v", v_w[l], 0);
      chk("rst_busy", busy_w[l], 0);
      chk("rst_done", done_w[l], 0);
      chk("rst_req", req_w[l], 0);
    end
    rst = 1'b1;

    // instantiate from zero, then plain updates on the 256-bit lane
    run(0, 1'b1, '0, 1, -1, 8);
    run(0, 1'b0, rnd384(), 1, -1, 8);

    // stalled core: +3 ack and +5 result cycles per block
    ack_dly = 4'd3;
    vld_dly = 4'd5;
    run(0, 1'b0, rnd384(), 1, -1, 32);
    ack_dly = 4'd0;
    vld_dly = 4'd0;

    // start held for 5 cycles, then a stray pulse mid-update, then a normal follow-up
    run(0, 1'b0, rnd384(), 5, -1, 8);
    run(0, 1'b0, rnd384(), 1, 4, 8);
    run(0, 1'b0, rnd384(), 1, -1, 8);

    // 128-bit key, 32-bit counter: preset V to an all-ones counter field, then wrap it
    keystream(1, '0, '0, 1'b0, ks);
    pdv = ks ^ {128'd0, 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0,
                128'h0123_4567_89AB_CDEF_FFFF_FFFF_FFFF_FFFF};
    run(1, 1'b1, pdv, 1, -1, 6);
    chk("preset_v", v_w[1], 128'h0123_4567_89AB_CDEF_FFFF_FFFF_FFFF_FFFF);
    run(1, 1'b0, rnd384(), 1, -1, 6);
    chk("ctr32_first_pt", first_pt, 128'h0123_4567_89AB_CDEF_FFFF_FFFF_0000_0000);

    // 192-bit key: three blocks, top 320 keystream bits used
    run(2, 1'b1, rnd384(), 1, -1, 8);
    run(2, 1'b0, rnd384(), 1, -1, 8);

    // reset while waiting for the second block's result
    vld_dly = 4'd3;
    pdv = rnd384();
    expect_update(0, 1'b0, pdv);
    hs_cnt = 0;
    @(posedge clk); #1;
    start_r[0] = 1'b1;
    pd_r[0]    = pdv;
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("busy_before_abort", busy_w[0], 1);
    chk("hs_before_abort", hs_cnt, 2);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_key", key_w[0], 0);
    chk("abort_v", v_w[0], 0);
    chk("abort_busy", busy_w[0], 0);
    chk("abort_done", done_w[0], 0);
    chk("abort_req", req_w[0], 0);
    rst = 1'b1;
    hs_q.delete();
    res_q.delete();
    for (int l = 0; l < 3; l++) begin
      mkey[l] = '0;
      mv[l]   = '0;
    end
    vld_dly = 4'd0;
    run(0, 1'b0, rnd384(), 1, -1, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
